// File: rtl/ifns_pkg.sv
// Shared constants, codeword type, weight table and crosstalk rule for the
// IFNS 21-wire receive decoder.
package ifns_pkg;

  localparam int CW = 21;
  localparam int DW = 15;

  typedef logic [CW-1:0] code_t;

  // Wire weights, index 0 = d1 ... index 20 = d21 (listed MSB first).
  localparam logic [CW-1:0][15:0] WEIGHTS = {
    16'd17711, 16'd6765, 16'd4181, 16'd2584, 16'd1597, 16'd987, 16'd610,
    16'd377,   16'd233,  16'd144,  16'd89,   16'd55,   16'd34,  16'd21,
    16'd13,    16'd8,    16'd5,    16'd3,    16'd2,    16'd1,   16'd1
  };

  // Two adjacent wires that both toggle, in opposite directions, are forbidden.
  function automatic logic ifns_xt_violation(input code_t prev, input code_t cur);
    logic v;
    v = 1'b0;
    for (int i = 0; i < CW - 1; i++)
      v = v | ((prev[i] ^ cur[i]) & (prev[i+1] ^ cur[i+1]) & (cur[i] ^ cur[i+1]));
    return v;
  endfunction

endpackage

// File: rtl/ifns_15di_sum16.sv
// Combinational weighted sum of a 21-wire codeword; max 35421 fits in 16 bits.
module ifns_15di_sum16
  import ifns_pkg::*;
(
  input  code_t       code,
  output logic [15:0] sum
);

  // Accumulate the weight of every asserted wire.
  always_comb begin
    sum = '0;
    for (int i = 0; i < CW; i++)
      if (code[i]) sum = sum + WEIGHTS[i];
  end

endmodule

// File: rtl/ifns_rx_decode_arb.sv
// Per-lane one-entry codeword buffers, round-robin grant into one shared
// decoder, registered output stage and saturating error counter.
module ifns_rx_decode_arb #(
  parameter int N_LANES = 4,
  parameter int CW      = ifns_pkg::CW,
  parameter int DW      = ifns_pkg::DW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_LANES-1:0]           in_valid,
  output logic [N_LANES-1:0]           in_ready,
  input  logic [N_LANES*CW-1:0]        in_code,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DW-1:0]                out_data,
  output logic [$clog2(N_LANES)-1:0]   out_lane,
  output logic                         out_xt_err,
  output logic                         out_rng_err,
  output logic [15:0]                  err_cnt,
  input  logic                         cnt_clr
);
  import ifns_pkg::*;

  localparam int LW = $clog2(N_LANES);

  logic [N_LANES-1:0]          full;
  logic [N_LANES-1:0][CW-1:0]  bufs;
  logic [N_LANES-1:0][CW-1:0]  prev;
  logic [LW-1:0]               last_grant;
  logic [LW-1:0]               win;
  logic                        found;
  logic                        grant;
  code_t                       cur;
  logic [15:0]                 sum;
  logic                        xt;
  logic                        word_err;

  assign in_ready = ~full;

  // Round-robin search: first full lane above the last winner, wrapping.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    for (int j = 1; j <= N_LANES; j++) begin
      idx = (int'(last_grant) + j) % N_LANES;
      if (!found && full[LW'(idx)]) begin
        found = 1'b1;
        win   = LW'(idx);
      end
    end
  end

  // Grant whenever something waits and the output register can take a word.
  assign grant    = found & (!out_valid | out_ready);
  assign cur      = bufs[win];
  assign xt       = ifns_xt_violation(prev[win], cur);
  assign word_err = xt | sum[DW];

  ifns_15di_sum16 u_sum (
    .code (cur),
    .sum  (sum)
  );

  // Lane buffers: grant empties (no same-cycle reload), handshake fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full       <= '0;
      bufs       <= '0;
      prev       <= '0;
      last_grant <= LW'(N_LANES - 1);
    end else begin
      for (int k = 0; k < N_LANES; k++) begin
        if (grant && win == LW'(k)) begin
          full[k] <= 1'b0;
          prev[k] <= bufs[k];
        end else if (in_valid[k] && !full[k]) begin
          full[k] <= 1'b1;
          bufs[k] <= in_code[k*CW +: CW];
        end
      end
      if (grant) last_grant <= win;
    end
  end

  // Output register: load on grant, drop valid when drained, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_lane    <= '0;
      out_xt_err  <= 1'b0;
      out_rng_err <= 1'b0;
    end else if (grant) begin
      out_valid   <= 1'b1;
      out_data    <= sum[DW-1:0];
      out_lane    <= win;
      out_xt_err  <= xt;
      out_rng_err <= sum[DW];
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // Saturating count of granted words carrying any error; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (cnt_clr)
      err_cnt <= '0;
    else if (grant && word_err && err_cnt != 16'hFFFF)
      err_cnt <= err_cnt + 16'd1;
  end

endmodule
